// File: rtl/alarm_pkg.sv
// Shared types and defaults for the alarm-clock datapath blocks.
// Holds the countdown timer state encoding and the default tick rate
// of the divided clock (cycles of clk_internal per second).
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  // Default number of clk_internal cycles per one-second step.
  localparam int unsigned TICKS_PER_SEC_DEFAULT = 16;

  // A new seconds value may be taken in every state except RUNNING.
  function automatic logic timer_can_load(input timer_state_t s);
    return (s != RUNNING);
  endfunction

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// tick_prescaler: counts enabled cycles and emits a one-cycle terminal
// tick every TICKS enabled cycles. Clearing forces the count to zero and
// wins over enable. While disabled the count is preserved, so a paused
// consumer resumes mid-second exactly where it stopped.
module tick_prescaler #(
  parameter int unsigned TICKS = 16,
  parameter int unsigned BITS  = $clog2(TICKS)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [BITS-1:0] LAST = BITS'(TICKS - 1);

  logic [BITS-1:0] cnt_q;
  logic [BITS-1:0] cnt_d;

  // Terminal count only counts as a tick on an enabled, non-cleared cycle.
  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

  // Next count: clear, wrap on terminal count, step when enabled, else hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + BITS'(1);
      end
    end
  end

  // Count register with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable seconds down-counter for the alarm clock.
// Prescales clk_internal to one-second ticks, counts the loaded value to
// zero and raises a sticky alarm plus a one-cycle expired_pulse.
// Optional build macro COUNTDOWN_AUTO_RELOAD_EN: on expiry reload the last
// loaded value and keep running instead of entering EXPIRED.
//
// Load handshake: a value transfers on a rising edge where load_valid and
// load_ready are both high. load_ready depends only on state (low while
// RUNNING); the producer holds load_valid and load_value stable until the
// transfer edge and must not rely on a load being taken while RUNNING.
module countdown_timer
  import alarm_pkg::*;
#(
  parameter int unsigned COUNTING_BITS = 16,
  parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEFAULT
) (
  input  logic                     clk_internal,
  input  logic                     reset,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [COUNTING_BITS-1:0] load_value,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     ack,
  output logic [COUNTING_BITS-1:0] remaining,
  output logic                     busy,
  output logic                     alarm,
  output logic                     expired_pulse,
  output timer_state_t             state_dbg
);

  // TICKS_PER_SEC must be at least 2 so a second spans several cycles.
  localparam int unsigned PRESCALE_BITS = $clog2(TICKS_PER_SEC);
  localparam logic [COUNTING_BITS-1:0] ONE = COUNTING_BITS'(1);

  timer_state_t             state_q;
  logic [COUNTING_BITS-1:0] remaining_q;
  logic                     alarm_q;
  logic                     pulse_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [COUNTING_BITS-1:0] reload_q;
`endif

  logic load_fire;
  logic idle_start;
  logic presc_en;
  logic presc_clr;
  logic sec_tick;

  assign load_ready = timer_can_load(state_q);
  assign load_fire  = load_valid && load_ready;

  // A start from IDLE only counts with a non-zero value and no load pending.
  assign idle_start = (state_q == IDLE) && start && !load_fire &&
                      (remaining_q != '0);

  // Pause freezes the prescaler on the same cycle it is seen, so a
  // coincident terminal count does not turn into a decrement.
  assign presc_en  = (state_q == RUNNING) && !pause;
  assign presc_clr = load_fire || idle_start;

  tick_prescaler #(
    .TICKS (TICKS_PER_SEC),
    .BITS  (PRESCALE_BITS)
  ) u_prescaler (
    .clk_i   (clk_internal),
    .reset_i (reset),
    .en_i    (presc_en),
    .clr_i   (presc_clr),
    .tick_o  (sec_tick)
  );

  // Timer FSM with registered remaining/alarm/pulse outputs.
  always_ff @(posedge clk_internal or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      alarm_q     <= 1'b0;
      pulse_q     <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q    <= '0;
`endif
    end else begin
      pulse_q <= 1'b0;
      // ack clears alarm in any state; an expiry below overrides it.
      if (ack) begin
        alarm_q <= 1'b0;
      end
      if (load_fire) begin
        remaining_q <= load_value;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_q    <= load_value;
`endif
      end
      case (state_q)
        IDLE: begin
          if (idle_start) begin
            state_q <= RUNNING;
          end
        end
        RUNNING: begin
          if (pause) begin
            state_q <= PAUSED;
          end else if (sec_tick) begin
            if (remaining_q == ONE) begin
              alarm_q <= 1'b1;
              pulse_q <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              if (reload_q != '0) begin
                remaining_q <= reload_q;
              end else begin
                remaining_q <= '0;
                state_q     <= EXPIRED;
              end
`else
              remaining_q <= '0;
              state_q     <= EXPIRED;
`endif
            end else if (remaining_q != '0) begin
              remaining_q <= remaining_q - ONE;
            end
          end
        end
        PAUSED: begin
          if (!load_fire && start && !pause) begin
            state_q <= RUNNING;
          end
        end
        EXPIRED: begin
          if (load_fire || ack) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign remaining     = remaining_q;
  assign busy          = (state_q == RUNNING);
  assign alarm         = alarm_q;
  assign expired_pulse = pulse_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICKS_PER_SEC=4, COUNTING_BITS=8.
// A scoreboard queue holds expected remaining values and their cycle
// offsets from the start edge; expected expiry pulses are queued the same way.
module tb_countdown_timer;
  import alarm_pkg::*;

  localparam int W = 8;

  logic         clk_internal;
  logic         reset;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_value;
  logic         start;
  logic         pause;
  logic         ack;
  logic [W-1:0] remaining;
  logic         busy;
  logic         alarm;
  logic         expired_pulse;
  timer_state_t state_dbg;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic mon_en = 1'b0;
  logic [W-1:0] rem_prev;

  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];
  int           pulse_t_q[$];

  countdown_timer #(
    .COUNTING_BITS (W),
    .TICKS_PER_SEC (4)
  ) dut (
    .clk_internal  (clk_internal),
    .reset         (reset),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_value    (load_value),
    .start         (start),
    .pause         (pause),
    .ack           (ack),
    .remaining     (remaining),
    .busy          (busy),
    .alarm         (alarm),
    .expired_pulse (expired_pulse),
    .state_dbg     (state_dbg)
  );

  // Clock and cycle counter
  initial begin
    clk_internal = 1'b0;
    forever #5 clk_internal = ~clk_internal;
  end

  always @(posedge clk_internal) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every change of remaining pops one expected value/time.
  always @(posedge clk_internal) begin
    #2;
    if (mon_en && (remaining !== rem_prev)) begin
      if (exp_q.size() == 0) begin
        chk("rem_extra_change", remaining, rem_prev);
      end else begin
        chk("rem_value", remaining, exp_q.pop_front());
        chk("rem_time", cyc - start_cyc, exp_t_q.pop_front());
      end
    end
    rem_prev = remaining;
  end

  // Scoreboard: every cycle with expired_pulse high pops one expected time.
  always @(posedge clk_internal) begin
    #2;
    if (expired_pulse === 1'b1) begin
      if (pulse_t_q.size() == 0) begin
        chk("pulse_extra", expired_pulse, 1'b0);
      end else begin
        chk("pulse_time", cyc - start_cyc, pulse_t_q.pop_front());
      end
    end
  end

  // Driver tasks: inputs change on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk_internal);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_value = v;
    load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
  endtask

  task automatic setup(input logic [W-1:0] v);
    mon_en = 1'b0;
    do_load(v);
    mon_en = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic push_rem(input logic [W-1:0] v, input int t);
    exp_q.push_back(v);
    exp_t_q.push_back(t);
  endtask

  initial begin
    reset = 1'b1;
    load_valid = 1'b0;
    load_value = '0;
    start = 1'b0;
    pause = 1'b0;
    ack = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);

    // Reset state
    chk("rst_state", state_dbg, IDLE);
    chk("rst_remaining", remaining, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_pulse", expired_pulse, 0);
    chk("rst_load_ready", load_ready, 1);

    // Basic countdown of 3
    setup(8'd3);
    chk("t1_loaded", remaining, 3);
    push_rem(8'd2, 4); push_rem(8'd1, 8); push_rem(8'd0, 12);
    pulse_t_q.push_back(12);
    do_start();
    chk("t1_busy", busy, 1);
    chk("t1_ready_running", load_ready, 0);
    step(12);
    chk("t1_state_exp", state_dbg, EXPIRED);
    chk("t1_alarm", alarm, 1);
    chk("t1_busy_exp", busy, 0);
    chk("t1_pulse", expired_pulse, 1);
    step(1);
    chk("t1_pulse_one_cycle", expired_pulse, 0);
    chk("t1_alarm_sticky", alarm, 1);
    chk("t1_rem_zero", remaining, 0);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("t1_ack_state", state_dbg, IDLE);
    chk("t1_ack_alarm", alarm, 0);

    // Pause/resume with preserved prescaler
    setup(8'd5);
    push_rem(8'd4, 4); push_rem(8'd3, 18); push_rem(8'd2, 22);
    push_rem(8'd1, 26); push_rem(8'd0, 30);
    pulse_t_q.push_back(30);
    do_start();
    step(6);
    pause = 1'b1;
    step(1);
    chk("t2_paused", state_dbg, PAUSED);
    chk("t2_paused_rem", remaining, 4);
    chk("t2_paused_busy", busy, 0);
    chk("t2_paused_ready", load_ready, 1);
    step(8);
    chk("t2_still_paused_rem", remaining, 4);
    pause = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t2_resumed", state_dbg, RUNNING);
    step(14);
    chk("t2_expired", state_dbg, EXPIRED);
    chk("t2_alarm", alarm, 1);

    // Load in EXPIRED returns to IDLE but keeps alarm
    mon_en = 1'b0;
    do_load(8'd7);
    chk("t2_load_exp_state", state_dbg, IDLE);
    chk("t2_load_exp_alarm", alarm, 1);
    chk("t2_load_exp_rem", remaining, 7);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("t2_ack_idle_alarm", alarm, 0);
    do_load(8'd0);

    // Start with zero is ignored
    start = 1'b1;
    step(3);
    start = 1'b0;
    chk("t3_zero_state", state_dbg, IDLE);
    chk("t3_zero_alarm", alarm, 0);
    chk("t3_zero_busy", busy, 0);

    // Load refused while running; ack on the expiry edge
    setup(8'd4);
    push_rem(8'd3, 4); push_rem(8'd2, 8); push_rem(8'd1, 12); push_rem(8'd0, 16);
    pulse_t_q.push_back(16);
    do_start();
    step(2);
    load_value = 8'h77;
    load_valid = 1'b1;
    #1;
    chk("t3_ready_running", load_ready, 0);
    step(1);
    load_valid = 1'b0;
    chk("t3_rem_unaffected", remaining, 4);
    step(12);
    ack = 1'b1;
    step(1);
    chk("t4_ack_on_expiry_alarm", alarm, 1);
    chk("t4_ack_on_expiry_state", state_dbg, EXPIRED);
    step(1);
    ack = 1'b0;
    chk("t4_ack_next_alarm", alarm, 0);
    chk("t4_ack_next_state", state_dbg, IDLE);

    // Asynchronous reset mid-count
    setup(8'd2);
    push_rem(8'd1, 4);
    do_start();
    step(5);
    mon_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("t5_rst_rem", remaining, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_alarm", alarm, 0);
    chk("t5_rst_pulse", expired_pulse, 0);
    chk("t5_rst_state", state_dbg, IDLE);
    step(2);
    reset = 1'b0;
    step(12);
    chk("t5_after_rst_state", state_dbg, IDLE);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Auto-reload keeps counting
    setup(8'd2);
    push_rem(8'd1, 4); push_rem(8'd2, 8); push_rem(8'd1, 12); push_rem(8'd2, 16);
    pulse_t_q.push_back(8);
    pulse_t_q.push_back(16);
    do_start();
    step(8);
    chk("t6_pulse1", expired_pulse, 1);
    chk("t6_busy1", busy, 1);
    chk("t6_alarm1", alarm, 1);
    chk("t6_reload1", remaining, 2);
    step(1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("t6_ack_alarm", alarm, 0);
    chk("t6_ack_busy", busy, 1);
    step(6);
    chk("t6_pulse2", expired_pulse, 1);
    chk("t6_alarm2", alarm, 1);
    step(1);
    mon_en = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
`endif

    step(2);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("pulse_q_drained", pulse_t_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
